// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, word type and arbiter states.
// Used by memory_arbiter and arb_req_latch.
package cpu_types_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t DGRANT = 2'd1;
    localparam arb_state_t IGRANT = 2'd2;

endpackage

// File: rtl/arb_req_latch.sv
// Holds the address/data/op of the granted requester and drives the RAM
// side from those registers so requester changes during a grant are ignored.
module arb_req_latch
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_load_d,
    input  logic              i_load_i,
    input  logic              i_active,
    input  logic [ADDR_W-1:0] i_daddr,
    input  logic [DATA_W-1:0] i_dstore,
    input  logic              i_dren,
    input  logic              i_dwen,
    input  logic [ADDR_W-1:0] i_iaddr,
    output logic              o_ramREN,
    output logic              o_ramWEN,
    output logic [ADDR_W-1:0] o_ramaddr,
    output logic [DATA_W-1:0] o_ramstore
);

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_ren;
    logic              r_wen;

    // Capture the winning request at arbitration time.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_addr <= '0;
            r_data <= '0;
            r_ren  <= 1'b0;
            r_wen  <= 1'b0;
        end else if (i_load_d) begin
            r_addr <= i_daddr;
            r_data <= i_dstore;
            r_ren  <= i_dren;
            r_wen  <= i_dwen;
        end else if (i_load_i) begin
            r_addr <= i_iaddr;
            r_data <= '0;
            r_ren  <= 1'b1;
            r_wen  <= 1'b0;
        end
    end

    assign o_ramREN   = i_active & r_ren;
    assign o_ramWEN   = i_active & r_wen;
    assign o_ramaddr  = r_addr;
    assign o_ramstore = r_data;

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the single-ported RAM between fetch and data paths, data first.
// Optional fetch starvation guard: define MEMORY_ARBITER_STARVE_GUARD_EN.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W       = ADDR_WIDTH,
    parameter int DATA_W       = DATA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic [15:0]       grant_cnt
);

    arb_state_t  r_state;
    arb_state_t  w_next;
    logic [15:0] r_cnt;
    logic        w_dreq;
    logic        w_d_done;
    logic        w_i_done;
    logic        w_i_abort;
    logic        w_pick_i;
    logic        w_load_d;
    logic        w_load_i;

    assign w_dreq    = dREN | dWEN;
    assign w_d_done  = (r_state == DGRANT) && (ramstate == ACCESS);
    assign w_i_done  = (r_state == IGRANT) && (ramstate == ACCESS) && iREN;
    assign w_i_abort = (r_state == IGRANT) && !iREN;

`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] r_starve;

    // Count data wins while a fetch waits; saturates, cleared by any fetch end.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_starve <= '0;
        end else if (w_i_done || w_i_abort) begin
            r_starve <= '0;
        end else if (w_d_done && iREN && r_starve != 3'd7) begin
            r_starve <= r_starve + 3'd1;
        end
    end

    assign w_pick_i = iREN && (!w_dreq || (r_starve >= LIMIT));
`else
    assign w_pick_i = iREN && !w_dreq;
`endif

    assign w_load_i = (r_state == IDLE) && w_pick_i;
    assign w_load_d = (r_state == IDLE) && w_dreq && !w_pick_i;

    // Next-state selection for the grant FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_load_d)      w_next = DGRANT;
                else if (w_load_i) w_next = IGRANT;
            end
            DGRANT: if (w_d_done) w_next = IDLE;
            IGRANT: if (w_i_done || w_i_abort) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Completed-access counter; aborts are not counted, wraps naturally.
    always_ff @(posedge CLK) begin
        if (!nRST)                     r_cnt <= '0;
        else if (w_d_done || w_i_done) r_cnt <= r_cnt + 16'd1;
    end

    arb_req_latch #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_latch (
        .CLK        (CLK),
        .nRST       (nRST),
        .i_load_d   (w_load_d),
        .i_load_i   (w_load_i),
        .i_active   (r_state != IDLE),
        .i_daddr    (daddr),
        .i_dstore   (dstore),
        .i_dren     (dREN),
        .i_dwen     (dWEN),
        .i_iaddr    (iaddr),
        .o_ramREN   (ramREN),
        .o_ramWEN   (ramWEN),
        .o_ramaddr  (ramaddr),
        .o_ramstore (ramstore)
    );

    assign iwait     = !w_i_done;
    assign dwait     = !w_d_done;
    assign iload     = w_i_done ? ramload : '0;
    assign dload     = w_d_done ? ramload : '0;
    assign grant_cnt = r_cnt;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed vector bench for memory_arbiter plus a starvation sequence.
// Expected values are hand-computed per cycle.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN;
    ramstate_t   ramstate;
    logic [15:0] grant_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    memory_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .grant_cnt(grant_cnt)
    );

    typedef struct {
        logic        rst;
        logic        ir, dr, dw;
        logic [31:0] ia, da, ds;
        ramstate_t   rs;
        logic [31:0] rl;
        logic        e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(
        logic rst, logic ir, logic dr, logic dw,
        logic [31:0] ia, logic [31:0] da, logic [31:0] ds,
        ramstate_t rs, logic [31:0] rl,
        logic iw, logic dwt, logic ren, logic wen,
        logic [31:0] addr, logic [31:0] st,
        logic [31:0] il, logic [31:0] dl, logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw;
        v.ia = ia; v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
        v.e_iw = iw; v.e_dw = dwt; v.e_ren = ren; v.e_wen = wen;
        v.e_addr = addr; v.e_store = st; v.e_il = il; v.e_dl = dl;
        v.e_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h",
                     name, idx, act, exp);
        end
    endtask

    int d_done, i_done, fetch_at, cyc;
    int exp_fetch_at;

    initial begin
        // rst ir dr dw ia da ds rs rl | iw dw ren wen addr store il dl cnt
        vecs[0]  = mk(0,0,0,0,0,0,0,FREE,0, 1,1,0,0,0,0,0,0,0);
        vecs[1]  = mk(1,1,0,0,32'h100,0,0,FREE,0, 1,1,0,0,0,0,0,0,0);
        vecs[2]  = mk(1,1,0,0,32'h100,0,0,ACCESS,32'h8C220004,
                      0,1,1,0,32'h100,0,32'h8C220004,0,0);
        vecs[3]  = mk(1,0,0,0,0,0,0,FREE,32'h8C220004,
                      1,1,0,0,32'h100,0,0,0,1);
        vecs[4]  = mk(1,1,1,0,32'h100,32'h200,0,FREE,0,
                      1,1,0,0,32'h100,0,0,0,1);
        vecs[5]  = mk(1,1,1,0,32'h100,32'h200,0,ACCESS,32'h11223344,
                      1,0,1,0,32'h200,0,0,32'h11223344,1);
        vecs[6]  = mk(1,1,0,0,32'h100,0,0,FREE,0,
                      1,1,0,0,32'h200,0,0,0,2);
        vecs[7]  = mk(1,1,0,0,32'h100,0,0,ACCESS,32'h55667788,
                      0,1,1,0,32'h100,0,32'h55667788,0,2);
        vecs[8]  = mk(1,0,0,0,0,0,0,FREE,0, 1,1,0,0,32'h100,0,0,0,3);
        vecs[9]  = mk(1,0,0,1,0,32'h3FC,32'hDEADBEEF,FREE,0,
                      1,1,0,0,32'h100,0,0,0,3);
        vecs[10] = mk(1,0,0,1,0,32'h3FC,32'hDEADBEEF,BUSY,0,
                      1,1,0,1,32'h3FC,32'hDEADBEEF,0,0,3);
        vecs[11] = mk(1,0,0,1,0,0,0,BUSY,0,
                      1,1,0,1,32'h3FC,32'hDEADBEEF,0,0,3);
        vecs[12] = mk(1,0,0,1,0,32'h3FC,32'hDEADBEEF,BUSY,0,
                      1,1,0,1,32'h3FC,32'hDEADBEEF,0,0,3);
        vecs[13] = mk(1,0,0,1,0,32'h3FC,32'hDEADBEEF,ACCESS,32'hA5A5A5A5,
                      1,0,0,1,32'h3FC,32'hDEADBEEF,0,32'hA5A5A5A5,3);
        vecs[14] = mk(1,0,0,0,0,0,0,FREE,0,
                      1,1,0,0,32'h3FC,32'hDEADBEEF,0,0,4);
        vecs[15] = mk(1,1,0,0,32'h104,0,0,FREE,0,
                      1,1,0,0,32'h3FC,32'hDEADBEEF,0,0,4);
        vecs[16] = mk(1,1,0,0,32'h104,0,0,BUSY,0,
                      1,1,1,0,32'h104,0,0,0,4);
        vecs[17] = mk(1,0,0,0,32'h104,0,0,BUSY,0,
                      1,1,1,0,32'h104,0,0,0,4);
        vecs[18] = mk(1,0,0,0,0,0,0,ACCESS,32'h12345678,
                      1,1,0,0,32'h104,0,0,0,4);
        vecs[19] = mk(1,0,1,0,0,32'h40,0,FREE,0,
                      1,1,0,0,32'h104,0,0,0,4);
        vecs[20] = mk(1,0,1,0,0,32'h40,0,BUSY,0,
                      1,1,1,0,32'h40,0,0,0,4);
        vecs[21] = mk(0,0,1,0,0,32'h40,0,BUSY,0,
                      1,1,1,0,32'h40,0,0,0,4);
        vecs[22] = mk(1,0,0,0,0,0,0,BUSY,0, 1,1,0,0,0,0,0,0,0);
        vecs[23] = mk(1,0,1,0,0,32'h80,0,FREE,0, 1,1,0,0,0,0,0,0,0);
        vecs[24] = mk(1,0,1,0,0,32'h80,0,ERROR,0,
                      1,1,1,0,32'h80,0,0,0,0);
        vecs[25] = mk(1,0,1,0,0,32'h80,0,ACCESS,32'hCAFEF00D,
                      1,0,1,0,32'h80,0,0,32'hCAFEF00D,0);
        vecs[26] = mk(1,0,0,0,0,0,0,FREE,0, 1,1,0,0,32'h80,0,0,0,1);

        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        repeat (2) @(posedge CLK);
        #1;

        for (int i = 0; i < NV; i++) begin
            nRST = vecs[i].rst; iREN = vecs[i].ir;
            dREN = vecs[i].dr; dWEN = vecs[i].dw;
            iaddr = vecs[i].ia; daddr = vecs[i].da; dstore = vecs[i].ds;
            ramstate = vecs[i].rs; ramload = vecs[i].rl;
            @(negedge CLK);
            check("iwait",     i, {31'd0, iwait},  {31'd0, vecs[i].e_iw});
            check("dwait",     i, {31'd0, dwait},  {31'd0, vecs[i].e_dw});
            check("ramREN",    i, {31'd0, ramREN}, {31'd0, vecs[i].e_ren});
            check("ramWEN",    i, {31'd0, ramWEN}, {31'd0, vecs[i].e_wen});
            check("ramaddr",   i, ramaddr,  vecs[i].e_addr);
            check("ramstore",  i, ramstore, vecs[i].e_store);
            check("iload",     i, iload,    vecs[i].e_il);
            check("dload",     i, dload,    vecs[i].e_dl);
            check("grant_cnt", i, {16'd0, grant_cnt}, {16'd0, vecs[i].e_cnt});
            @(posedge CLK);
            #1;
        end

        // Fetch held while five data reads arrive back to back.
`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
        exp_fetch_at = 4;
`else
        exp_fetch_at = 5;
`endif
        d_done = 0; i_done = 0; fetch_at = -1; cyc = 0;
        iREN = 1; iaddr = 32'h500; dREN = 1; daddr = 32'h600;
        ramstate = ACCESS; ramload = 32'h0BADF00D;
        while (!(i_done > 0 && d_done >= 5) && cyc < 60) begin
            @(negedge CLK);
            if (!dwait) begin
                check("starve_daddr", d_done, ramaddr, 32'h600);
                d_done++;
            end
            if (!iwait) begin
                check("starve_iaddr", i_done, ramaddr, 32'h500);
                if (i_done == 0) fetch_at = d_done;
                i_done++;
            end
            @(posedge CLK);
            #1;
            dREN = (d_done < 5);
            cyc++;
        end
        check("starve_timeout", cyc, {31'd0, cyc >= 60}, 32'd0);
        check("starve_fetch_at", 0, fetch_at, exp_fetch_at);
        @(negedge CLK);
        check("starve_cnt", 0, {16'd0, grant_cnt}, 32'd7);
        iREN = 0; dREN = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
